// File: rtl/regfile_wsched_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wsched_pkg
// Shared types for the register-file write scheduler.
//   wr_req_t       : one buffered write (destination register + data word)
//   wsched_state_e : scheduler FSM states
//   NUM_REGS       : size of the integer register file that gets scrubbed
//   DW             : storage width of a buffered data word; the scheduler's
//                    DATA_WIDTH must not exceed it
// -----------------------------------------------------------------------------
package regfile_wsched_pkg;

    localparam int NUM_REGS = 32;
    localparam int DW       = 64;

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {
        SCRUB = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } wsched_state_e;

endpackage

// File: rtl/regfile_wsched_fifo.sv
// -----------------------------------------------------------------------------
// regfile_wsched_fifo
// In-order circular buffer of write requests. Up to NR_IN pushes per cycle
// (compacted in port-index order, lowest index oldest) and up to NR_OUT pops
// per cycle (min(count, NR_OUT) oldest entries). The caller guarantees it never
// pushes more than the free space. DEPTH is a power of two, >= 2, and >= both
// NR_IN and NR_OUT.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   push_i          per-port push strobe
//   push_req_i      per-port request to push
//   pop_valid_o     pop slot k carries an entry this cycle
//   pop_req_o       popped entries, oldest on slot 0
//   entries_o       raw storage (physical slot order) for forwarding search
//   valid_o         per-slot valid mask
//   head_o          physical index of the oldest entry
//   count_o         registered number of valid entries
// -----------------------------------------------------------------------------
module regfile_wsched_fifo
    import regfile_wsched_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int NR_IN  = 2,
    parameter  int NR_OUT = 1,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NR_IN-1:0]     push_i,
    input  wr_req_t [NR_IN-1:0]  push_req_i,
    output logic [NR_OUT-1:0]    pop_valid_o,
    output wr_req_t [NR_OUT-1:0] pop_req_o,
    output wr_req_t [DEPTH-1:0]  entries_o,
    output logic [DEPTH-1:0]     valid_o,
    output logic [PW-1:0]        head_o,
    output logic [CW-1:0]        count_o
);

    wr_req_t [DEPTH-1:0]   r_mem;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         w_push_cnt;
    logic [CW-1:0]         w_pop_cnt;
    logic [NR_IN-1:0][PW-1:0] w_wr_idx;

    // Compact the active pushes onto consecutive slots starting at the tail.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path can leave it unassigned and infer a latch.
    always_comb begin
        w_push_cnt = '0;
        for (int i = 0; i < NR_IN; i++) begin
            w_wr_idx[i] = r_tail + w_push_cnt[PW-1:0];
            if (push_i[i]) begin
                w_push_cnt = w_push_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        w_pop_cnt = (r_count < CW'(NR_OUT)) ? r_count : CW'(NR_OUT);
        for (int k = 0; k < NR_OUT; k++) begin
            pop_valid_o[k] = CW'(k) < r_count;
            pop_req_o[k]   = r_mem[r_head + PW'(k)];
        end
        // A slot is live when its distance from the head is below the count.
        for (int j = 0; j < DEPTH; j++) begin
            valid_o[j] = {1'b0, PW'(j) - r_head} < r_count;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_pop_cnt[PW-1:0];
            r_tail  <= r_tail + w_push_cnt[PW-1:0];
            r_count <= r_count + w_push_cnt - w_pop_cnt;
        end
    end

    // NOTE: the storage array is deliberately not reset; validity comes from
    // head/count, and leaving it reset-free lets it map onto distributed RAM.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_IN; i++) begin
            if (push_i[i]) begin
                r_mem[w_wr_idx[i]] <= push_req_i[i];
            end
        end
    end

    assign entries_o = r_mem;
    assign head_o    = r_head;
    assign count_o   = r_count;

endmodule

// File: rtl/regfile_wr_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wr_scheduler
// Sequences every write into the distributed-RAM integer register file:
// buffers commit-stage writes in order, drains them onto the physical write
// ports, and scrubs all 32 registers to zero after reset or on request.
// Optional macro: REGFILE_WSCHED_BYPASS_EN enables forwarding of pending
// buffered values to the read ports; otherwise fwd_* are tied to 0 and the
// issue stage must stall reads while occupancy_o != 0.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   scrub_req_i     pulse: drain the buffer then zero the regfile
//   busy_o          high outside RUN (draining for scrub or scrubbing)
//   in_valid_i / in_ready_o / in_addr_i / in_data_i   commit write requests
//   we_o / waddr_o / wdata_o                          regfile write ports
//   occupancy_o     registered number of buffered entries
//   raddr_i / fwd_hit_o / fwd_data_o                  read-port forwarding
// -----------------------------------------------------------------------------
module regfile_wr_scheduler
    import regfile_wsched_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int NR_IN_PORTS   = 2,
    parameter int NR_OUT_PORTS  = 1,
    parameter int NR_READ_PORTS = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      scrub_req_i,
    output logic                                      busy_o,
    input  logic [NR_IN_PORTS-1:0]                    in_valid_i,
    output logic [NR_IN_PORTS-1:0]                    in_ready_o,
    input  logic [NR_IN_PORTS-1:0][4:0]               in_addr_i,
    input  logic [NR_IN_PORTS-1:0][DATA_WIDTH-1:0]    in_data_i,
    output logic [NR_OUT_PORTS-1:0]                   we_o,
    output logic [NR_OUT_PORTS-1:0][4:0]              waddr_o,
    output logic [NR_OUT_PORTS-1:0][DATA_WIDTH-1:0]   wdata_o,
    output logic [$clog2(FIFO_DEPTH):0]               occupancy_o,
    input  logic [NR_READ_PORTS-1:0][4:0]             raddr_i,
    output logic [NR_READ_PORTS-1:0]                  fwd_hit_o,
    output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  fwd_data_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wsched_state_e               r_state;
    wsched_state_e               w_state_nxt;
    logic [4:0]                  r_scrub_cnt;
    logic [5:0]                  w_scrub_sum;
    logic                        w_ready;
    logic [NR_IN_PORTS-1:0]      w_push;
    wr_req_t [NR_IN_PORTS-1:0]   w_push_req;
    logic [NR_OUT_PORTS-1:0]     w_pop_valid;
    wr_req_t [NR_OUT_PORTS-1:0]  w_pop_req;
    wr_req_t [FIFO_DEPTH-1:0]    w_entries;
    logic [FIFO_DEPTH-1:0]       w_valid;
    logic [PW-1:0]               w_head;
    logic [CW-1:0]               w_count;

    // The carry out of the scrub counter marks the last scrub step.
    assign w_scrub_sum = {1'b0, r_scrub_cnt} + 6'(NR_OUT_PORTS);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SCRUB:   if (w_scrub_sum[5])      w_state_nxt = RUN;
            RUN:     if (scrub_req_i)         w_state_nxt = DRAIN;
            DRAIN:   if (w_count == '0)       w_state_nxt = SCRUB;
            default:                          w_state_nxt = SCRUB;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= SCRUB;
            r_scrub_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // Held at zero outside SCRUB so every scrub pass starts at x0.
            r_scrub_cnt <= (r_state == SCRUB) ? w_scrub_sum[4:0] : '0;
        end
    end

    // All-or-nothing ready from the registered count: every port can be
    // accepted whenever any is, so commit never splits a group.
    assign w_ready    = (r_state == RUN) &&
                        ((CW'(FIFO_DEPTH) - w_count) >= CW'(NR_IN_PORTS));
    assign in_ready_o = {NR_IN_PORTS{w_ready}};

    // Writes to x0 complete the handshake but are dropped here.
    always_comb begin
        for (int i = 0; i < NR_IN_PORTS; i++) begin
            w_push[i]          = in_valid_i[i] && w_ready && (in_addr_i[i] != 5'd0);
            w_push_req[i].addr = in_addr_i[i];
            w_push_req[i].data = DW'(in_data_i[i]);
        end
    end

    regfile_wsched_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .NR_IN  (NR_IN_PORTS),
        .NR_OUT (NR_OUT_PORTS)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (w_push),
        .push_req_i  (w_push_req),
        .pop_valid_o (w_pop_valid),
        .pop_req_o   (w_pop_req),
        .entries_o   (w_entries),
        .valid_o     (w_valid),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    // Oldest pop on port 0 so the regfile's highest-port-wins rule keeps
    // program order on equal addresses. The buffer is empty during SCRUB.
    always_comb begin
        for (int k = 0; k < NR_OUT_PORTS; k++) begin
            if (r_state == SCRUB) begin
                we_o[k]    = 1'b1;
                waddr_o[k] = r_scrub_cnt + 5'(k);
                wdata_o[k] = '0;
            end else begin
                we_o[k]    = w_pop_valid[k];
                waddr_o[k] = w_pop_req[k].addr;
                wdata_o[k] = w_pop_req[k].data[DATA_WIDTH-1:0];
            end
        end
    end

    assign occupancy_o = w_count;
    assign busy_o      = (r_state != RUN);

`ifdef REGFILE_WSCHED_BYPASS_EN
    logic [PW-1:0] w_slot;

    // Walk entries oldest to youngest so the youngest match is left standing.
    always_comb begin
        w_slot = '0;
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            fwd_hit_o[r]  = 1'b0;
            fwd_data_o[r] = '0;
            for (int a = 0; a < FIFO_DEPTH; a++) begin
                w_slot = w_head + PW'(a);
                if (w_valid[w_slot] && (w_entries[w_slot].addr == raddr_i[r])) begin
                    fwd_hit_o[r]  = 1'b1;
                    fwd_data_o[r] = w_entries[w_slot].data[DATA_WIDTH-1:0];
                end
            end
            if ((raddr_i[r] == 5'd0) || (r_state == SCRUB)) begin
                fwd_hit_o[r] = 1'b0;
            end
        end
    end
`else
    logic w_unused_fwd;

    assign fwd_hit_o    = '0;
    assign fwd_data_o   = '0;
    assign w_unused_fwd = ^{raddr_i, w_entries, w_valid, w_head};
`endif

endmodule
